// File: rtl/ask_uart_rx_if.sv
// ask_uart_rx_if
// Read-side bus of the ASK UART receiver FIFO.
//   fifo_out   : head byte of the FIFO (first-word fall-through)
//   fifo_read  : consumer pops the head byte
//   fifo_empty : FIFO holds no bytes
//   fifo_level : number of occupied entries
// Modports: master = receiver (drives data/status), slave = consumer.
interface ask_uart_rx_if;
    logic [7:0]  fifo_out;
    logic        fifo_read;
    logic        fifo_empty;
    logic [15:0] fifo_level;

    modport master (output fifo_out, output fifo_empty, output fifo_level, input fifo_read);
    modport slave  (input fifo_out, input fifo_empty, input fifo_level, output fifo_read);
endinterface

// File: rtl/ask_uart_rx.sv
// ask_uart_rx
// ASK receiver: carrier detect on signed samples -> UART line (carrier = 0,
// silence = 1) -> 8N1 frame decoder -> first-word-fall-through byte FIFO.
// Ports:
//   clk, rst   : single clock, asynchronous active-high reset
//   ask_rx     : signed ASK sample, one per clock
//   clkdiv     : bit period in clk cycles (frames ignored below 4)
//   threshold  : unsigned carrier-detect magnitude, 0 disables detection
//   fifo       : ask_uart_rx_if.master read port (fifo_out/read/empty/level)
//   frame_err  : one-cycle pulse, stop bit sampled as 0
//   overrun    : one-cycle pulse, good byte dropped on a full FIFO
//   line       : demodulated UART line (debug)
// Build option: define ASK_RX_MAJORITY_EN for 2-of-3 majority bit sampling
// (decisions and all FIFO/flag timing move one cycle later).
module ask_uart_rx #(
    parameter int ask_rx_length = 8,
    parameter int SIZE          = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [ask_rx_length-1:0] ask_rx,
    input  logic [15:0]                     clkdiv,
    input  logic [ask_rx_length-2:0]        threshold,
    ask_uart_rx_if.master                   fifo,
    output logic                            frame_err,
    output logic                            overrun,
    output logic                            line
);
    localparam int MW = ask_rx_length - 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t       state, state_next;
    logic [MW-1:0] mag, mag_neg;
    logic         hit;
    logic [15:0]  hold_ctr;
    logic [15:0]  baud_ctr;
    logic [15:0]  div_l;
    logic [2:0]   bit_ctr;
    logic [7:0]   shift;
    logic         push_r;
    logic         sample_now, sample_val;
    logic         start_det, bit_take, push_now, err_now;

    // Absolute value of the sample. For negatives the low bits of -x equal
    // ~x+1 truncated; the most negative value wraps to 0 there, so it is
    // saturated to all ones instead.
    assign mag_neg = ~ask_rx[MW-1:0] + {{(MW-1){1'b0}}, 1'b1};
    always_comb begin
        mag = ask_rx[MW-1:0];
        if (ask_rx[MW]) begin
            mag = (ask_rx[MW-1:0] == '0) ? '1 : mag_neg;
        end
    end

    assign hit = (threshold != '0) && (mag >= threshold);

    // Carrier detector: the hold counter keeps the line low across the
    // carrier's zero crossings, where single samples fall below threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_ctr <= '0;
            line     <= 1'b1;
        end else begin
            if (hit) begin
                hold_ctr <= clkdiv >> 2;
            end else if (hold_ctr != 16'd0) begin
                hold_ctr <= hold_ctr - 16'd1;
            end
            line <= ~(hit || (hold_ctr != 16'd0));
        end
    end

`ifdef ASK_RX_MAJORITY_EN
    logic maj_s1, maj_s0, maj_pend;

    // Capture line at baud counts 1 and 0; the vote is taken one cycle later
    // together with the current line value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maj_s1   <= 1'b1;
            maj_s0   <= 1'b1;
            maj_pend <= 1'b0;
        end else begin
            if (baud_ctr == 16'd1) maj_s1 <= line;
            if (baud_ctr == 16'd0) maj_s0 <= line;
            maj_pend <= (state != IDLE) && (baud_ctr == 16'd0);
        end
    end

    assign sample_now = maj_pend;
    assign sample_val = (maj_s1 & maj_s0) | (maj_s1 & line) | (maj_s0 & line);
`else
    assign sample_now = (state != IDLE) && (baud_ctr == 16'd0);
    assign sample_val = line;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Frame sequencing; the strobes drive the datapath register block below.
    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        bit_take   = 1'b0;
        push_now   = 1'b0;
        err_now    = 1'b0;
        case (state)
            IDLE: begin
                if (!line && (clkdiv >= 16'd4)) begin
                    start_det  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (sample_now) state_next = sample_val ? IDLE : DATA;
            end
            DATA: begin
                if (sample_now) begin
                    bit_take = 1'b1;
                    if (bit_ctr == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (sample_now) begin
                    push_now   = sample_val;
                    err_now    = ~sample_val;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Baud counter free-runs with the latched period while a frame is in
    // progress, so mid-frame clkdiv changes only affect the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_ctr  <= '0;
            div_l     <= '0;
            bit_ctr   <= '0;
            shift     <= '0;
            push_r    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (start_det) begin
                    div_l    <= clkdiv;
                    baud_ctr <= clkdiv >> 1;
                    bit_ctr  <= 3'd0;
                end
            end else if (baud_ctr == 16'd0) begin
                baud_ctr <= div_l - 16'd1;
            end else begin
                baud_ctr <= baud_ctr - 16'd1;
            end
            if (bit_take) begin
                shift[bit_ctr] <= sample_val;
                bit_ctr        <= bit_ctr + 3'd1;
            end
            push_r    <= push_now;
            frame_err <= err_now;
        end
    end

    // FIFO with one extra pointer bit to tell full from empty.
    localparam int DEPTH = 1 << SIZE;

    logic [7:0]  mem [DEPTH];
    logic [SIZE:0] wr_ptr, rd_ptr, level;
    logic        empty, full, do_pop, do_push;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[SIZE] != rd_ptr[SIZE]) &&
                     (wr_ptr[SIZE-1:0] == rd_ptr[SIZE-1:0]);
    assign do_pop  = fifo.fifo_read && !empty;
    // A push into a full FIFO still lands when a pop frees the slot this cycle.
    assign do_push = push_r && (!full || do_pop);
    assign overrun = push_r && full && !fifo.fifo_read;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[SIZE-1:0]] <= shift;
    end

    assign fifo.fifo_out   = mem[rd_ptr[SIZE-1:0]];
    assign fifo.fifo_empty = empty;
    assign fifo.fifo_level = {{(15-SIZE){1'b0}}, level};
endmodule

// File: tb/tb_ask_uart_rx.sv
// tb_ask_uart_rx
// Directed bench for ask_uart_rx: an ASK transmitter model drives frames,
// expected bytes go into a scoreboard queue and are compared as the FIFO is
// read. Flag pulses are counted by a negedge monitor.
module tb_ask_uart_rx;
    localparam int N     = 8;
    localparam int SZ    = 2;
    localparam int DEPTH = 1 << SZ;
    localparam int DIV   = 32;
    localparam int FRAME = 10 * DIV;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] ask_rx;
    logic [15:0]       clkdiv;
    logic [6:0]        threshold;
    logic              frame_err, overrun, line;

    ask_uart_rx_if fifo_bus ();

    ask_uart_rx #(.ask_rx_length(N), .SIZE(SZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .ask_rx    (ask_rx),
        .clkdiv    (clkdiv),
        .threshold (threshold),
        .fifo      (fifo_bus),
        .frame_err (frame_err),
        .overrun   (overrun),
        .line      (line)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int model_level = 0;
    int exp_ovr  = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] lvl_307, lvl_308;
    logic signed [7:0] wave [8] = '{8'sd0, 8'sd70, 8'sd100, 8'sd70,
                                    8'sd0, -8'sd70, -8'sd100, -8'sd70};

    // Counts flag pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr++;
        if (overrun === 1'b1)   n_ovr++;
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick;
            ask_rx = 8'sd0;
        end
    endtask

    // One 8N1 frame from the transmitter model. stop_carrier forces carrier
    // over the first samples of the stop bit; read_at pops the FIFO while
    // that sample is on the input.
    task automatic apply_stimulus(input logic [7:0] data, input int stop_carrier, input int read_at);
        int   b;
        logic carrier;
        if (stop_carrier == 0) begin
            if (model_level < DEPTH || read_at >= 0) begin
                exp_q.push_back(data);
                if (read_at < 0) model_level++;
            end else begin
                exp_ovr++;
            end
        end
        for (int k = 0; k < FRAME; k++) begin
            tick;
            b = k / DIV;
            if (b == 0)      carrier = 1'b1;
            else if (b <= 8) carrier = ~data[b-1];
            else             carrier = (k - 9 * DIV) < stop_carrier;
            ask_rx = carrier ? wave[(k + 1) % 8] : 8'sd0;
            if (k == read_at) begin
                check_output("overlap_head", {24'd0, fifo_bus.fifo_out}, {24'd0, exp_q.pop_front()});
                fifo_bus.fifo_read = 1'b1;
            end else begin
                fifo_bus.fifo_read = 1'b0;
            end
            if (k == 307) lvl_307 = fifo_bus.fifo_level;
            if (k == 308) lvl_308 = fifo_bus.fifo_level;
        end
    endtask

    // Pops everything the DUT holds and matches it against the scoreboard.
    task automatic drain(input string tag);
        for (int i = 0; i < 3 * DEPTH && fifo_bus.fifo_empty === 1'b0; i++) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("[TB] FAIL %s: observed=0x%0h expected=no_byte", tag, fifo_bus.fifo_out);
            end else begin
                check_output(tag, {24'd0, fifo_bus.fifo_out}, {24'd0, exp_q.pop_front()});
            end
            fifo_bus.fifo_read = 1'b1;
            tick;
            fifo_bus.fifo_read = 1'b0;
            if (model_level > 0) model_level--;
        end
        check_output({tag, "_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int f0, o0;
        logic [7:0] burst [6] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80};

        rst = 1'b1;
        ask_rx = 8'sd0;
        clkdiv = 16'(DIV);
        threshold = 7'd40;
        fifo_bus.fifo_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        check_output("rst_line", line, 1);
        check_output("rst_empty", fifo_bus.fifo_empty, 1);
        check_output("rst_level", fifo_bus.fifo_level, 0);
        check_output("rst_frame_err", frame_err, 0);
        check_output("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(8);

        $display("[TB] clean byte 0xA5");
        f0 = n_ferr;
        apply_stimulus(8'hA5, 0, -1);
        idle(8);
        check_output("clean_level_before_push", lvl_307, 0);
        check_output("clean_level_after_push", lvl_308, 1);
        check_output("clean_level", fifo_bus.fifo_level, 1);
        check_output("clean_empty", fifo_bus.fifo_empty, 0);
        check_output("clean_frame_err", n_ferr - f0, 0);
        drain("clean_byte");
        check_output("clean_drained", fifo_bus.fifo_level, 0);

        $display("[TB] burst to full");
        o0 = n_ovr;
        exp_ovr = 0;
        foreach (burst[i]) apply_stimulus(burst[i], 0, -1);
        idle(8);
        check_output("burst_level", fifo_bus.fifo_level, DEPTH);
        check_output("burst_overrun", n_ovr - o0, exp_ovr);
        drain("burst_byte");
        check_output("burst_empty", fifo_bus.fifo_empty, 1);

        // Carrier covers the stop sample but ends early enough that the
        // decoder rejects the trailing carrier as a false start.
        $display("[TB] framing error 0x3C");
        f0 = n_ferr;
        apply_stimulus(8'h3C, 22, -1);
        idle(64);
        check_output("ferr_pulses", n_ferr - f0, 1);
        check_output("ferr_level", fifo_bus.fifo_level, 0);
        check_output("ferr_empty", fifo_bus.fifo_empty, 1);

        $display("[TB] carrier glitch");
        f0 = n_ferr;
        for (int k = 0; k < DIV / 8; k++) begin
            tick;
            ask_rx = wave[(k + 1) % 8];
        end
        idle(80);
        check_output("glitch_level", fifo_bus.fifo_level, 0);
        check_output("glitch_frame_err", n_ferr - f0, 0);
        apply_stimulus(8'h5A, 0, -1);
        idle(8);
        check_output("after_glitch_level", fifo_bus.fifo_level, 1);
        drain("after_glitch_byte");

        $display("[TB] threshold zero");
        threshold = 7'd0;
        for (int k = 0; k < 100; k++) begin
            tick;
            ask_rx = wave[(k + 1) % 8];
            if (k == 10 || k == 50 || k == 99) check_output("thr0_line", line, 1);
        end
        idle(4);
        threshold = 7'd40;
        idle(400);
        check_output("thr0_level", fifo_bus.fifo_level, 0);

        $display("[TB] push with read while full");
        foreach (burst[i]) if (i < DEPTH) apply_stimulus(8'h11 * (i + 1), 0, -1);
        o0 = n_ovr;
        apply_stimulus(8'h99, 0, 307);
        idle(8);
        check_output("overlap_overrun", n_ovr - o0, 0);
        check_output("overlap_level", fifo_bus.fifo_level, DEPTH);
        drain("overlap_byte");

        $display("[TB] reset mid-frame");
        apply_stimulus(8'hC3, 0, -1);
        idle(4);
        check_output("prereset_level", fifo_bus.fifo_level, 1);
        for (int k = 0; k < 100; k++) begin
            tick;
            ask_rx = wave[(k + 1) % 8];
        end
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_line", line, 1);
        check_output("async_rst_empty", fifo_bus.fifo_empty, 1);
        check_output("async_rst_level", fifo_bus.fifo_level, 0);
        exp_q.delete();
        model_level = 0;
        f0 = n_ferr;
        tick;
        rst = 1'b0;
        idle(400);
        check_output("postrst_level", fifo_bus.fifo_level, 0);
        check_output("postrst_frame_err", n_ferr - f0, 0);

        $display("[TB] full-scale magnitude");
        threshold = 7'd127;
        ask_rx = -8'sd128;
        repeat (3) tick;
        check_output("neg_full_scale_line", line, 0);
        ask_rx = 8'sd126;
        repeat (DIV / 4 + 3) tick;
        check_output("below_thr_line", line, 1);
        ask_rx = 8'sd127;
        repeat (2) tick;
        check_output("pos_full_scale_line", line, 0);

        rst = 1'b1;
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
